// File: rtl/lzrw1_decompressor_if.sv
// lzrw1_decompressor_if: compressed-item handshake and reconstructed-byte output of the LZRW1 decompressor
interface lzrw1_decompressor_if;
  logic [15:0] data_in;
  logic control_word_in;
  logic data_in_valid;
  logic [7:0] decompressed_byte;
  logic out_valid;
  logic decompressor_busy;
  modport master(output data_in, control_word_in, data_in_valid,
                 input decompressed_byte, out_valid, decompressor_busy);
  modport slave(input data_in, control_word_in, data_in_valid,
                output decompressed_byte, out_valid, decompressor_busy);
endinterface

// File: rtl/lzrw1_decompressor.sv
// lzrw1_decompressor: streaming LZRW1 decoder, one literal or copy item in, one byte per cycle out
module lzrw1_decompressor #(
  parameter int HISTORY_SIZE = 256
) (
  input logic clock,
  input logic reset,
  lzrw1_decompressor_if.slave bus
);
  localparam int AW = $clog2(HISTORY_SIZE);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [11:0] off_q, off_d;
  logic cw_q, cw_d;
  logic [4:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [7:0] byte_q, byte_d;
  logic ov_q, ov_d;
  logic we;
  logic [7:0] emit_b;
  logic [7:0] hist_q [HISTORY_SIZE];
  // a literal's byte shares the low offset field, so only the offset is kept
  assign emit_b = cw_q ? hist_q[wp_q - AW'(off_q)] : off_q[7:0];
  assign bus.decompressed_byte = byte_q;
  assign bus.out_valid = ov_q;
  assign bus.decompressor_busy = state_q == EMIT;
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    cw_d = cw_q;
    cnt_d = cnt_q;
    wp_d = wp_q;
    byte_d = byte_q;
    ov_d = 1'b0;
    we = 1'b0;
    if (state_q == IDLE) begin
      if (bus.data_in_valid) begin
        state_d = EMIT;
        off_d = {bus.data_in[15:12], bus.data_in[7:0]};
        cw_d = bus.control_word_in;
        cnt_d = bus.control_word_in ? {1'b0, bus.data_in[11:8]} + 5'd3 : 5'd1;
      end
    end else begin
      byte_d = emit_b;
      ov_d = 1'b1;
      we = 1'b1;
      wp_d = wp_q + AW'(1);
      cnt_d = cnt_q - 5'd1;
      state_d = cnt_q == 5'd1 ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q <= '0;
      cw_q <= 1'b0;
      cnt_q <= '0;
      wp_q <= '0;
      byte_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      cw_q <= cw_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      byte_q <= byte_d;
      ov_q <= ov_d;
    end
  end
  always_ff @(posedge clock) begin
    if (we) hist_q[wp_q] <= emit_b;
  end
endmodule

// File: tb/tb_lzrw1_decompressor.sv
// tb_lzrw1_decompressor: directed checks of the LZRW1 decompressor at history depths 256 and 16
module tb_lzrw1_decompressor;
  logic clock;
  logic reset;
  int vecs;
  int fails;
  lzrw1_decompressor_if b();
  lzrw1_decompressor_if b16();
  assign b16.data_in = b.data_in;
  assign b16.control_word_in = b.control_word_in;
  assign b16.data_in_valid = b.data_in_valid;
  lzrw1_decompressor dut (.clock(clock), .reset(reset), .bus(b));
  lzrw1_decompressor #(.HISTORY_SIZE(16)) dut16 (.clock(clock), .reset(reset), .bus(b16));
  logic [9:0] o, o16;
  assign o = {b.out_valid, b.decompressed_byte, b.decompressor_busy};
  assign o16 = {b16.out_valid, b16.decompressed_byte, b16.decompressor_busy};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // accept at the next edge, then expect n bytes of exp on n consecutive cycles
  task automatic item(input string nm, input logic [15:0] d, input logic c, input int n,
                      input string exp, input bit noise);
    logic [9:0] e, m;
    b.data_in = d;
    b.control_word_in = c;
    b.data_in_valid = 1'b1;
    for (int j = 0; j <= n; j++) begin
      @(negedge clock);
      if (noise && j < n) begin
        b.data_in = 16'($urandom);
        b.control_word_in = 1'($urandom);
        b.data_in_valid = 1'b1;
      end else b.data_in_valid = 1'b0;
      e = {j > 0, j > 0 ? 8'(exp[j-1]) : 8'h00, j < n};
      m = j > 0 ? 10'h3ff : 10'h201;
      vecs++;
      if (({o, o16} & {m, m}) !== {e & m, e & m}) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h/%h want %h mask %h", nm, j, o, o16, e, m);
      end
    end
  endtask
  task automatic idle_chk(input string nm);
    @(negedge clock);
    vecs++;
    if ({o[9], o[0], o16[9], o16[0]} !== 4'b0000) begin
      fails++;
      $display("FAIL %s: got %h/%h want out_valid=0 busy=0", nm, o, o16);
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    b.data_in = 16'h0041;
    b.control_word_in = 1'b0;
    b.data_in_valid = 1'b0;
    repeat (2) @(negedge clock);
    vecs++;
    if ({o, o16} !== 20'h0) begin
      fails++;
      $display("FAIL reset_state: got %h/%h want 000/000", o, o16);
    end
    reset = 1'b1;
    @(negedge clock);
    vecs++;
    if ({o, o16} !== 20'h0) begin
      fails++;
      $display("FAIL idle_no_valid: got %h/%h want 000/000", o, o16);
    end
  endtask
  task automatic test_literal();
    item("literal_A", 16'h0041, 1'b0, 1, "A", 0);
    idle_chk("literal_A_after");
  endtask
  task automatic test_copy();
    item("lit_a", 16'h0061, 1'b0, 1, "a", 0);
    item("lit_b", 16'h0062, 1'b0, 1, "b", 0);
    item("lit_c", 16'h0063, 1'b0, 1, "c", 0);
    item("copy_abc", 16'h0003, 1'b1, 3, "abc", 0);
  endtask
  task automatic test_overlap(input bit noise);
    string s;
    s = "";
    for (int i = 0; i < 18; i++) s = {s, "x"};
    item("lit_x", 16'h0078, 1'b0, 1, "x", 0);
    item(noise ? "copy_x18_noisy" : "copy_x18", 16'h0F01, 1'b1, 18, s, noise);
  endtask
  task automatic test_ignore();
    test_overlap(1);
    item("after_noise", 16'hFF42, 1'b0, 1, "B", 0);
    idle_chk("after_noise_idle");
  endtask
  task automatic test_wrap();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++)
      item("wrap_lit", 16'(65 + i), 1'b0, 1, $sformatf("%c", 65 + i), 0);
    item("wrap_copy", 16'h0104, 1'b1, 4, "QRST", 0);
  endtask
  task automatic test_reset_mid();
    item("mid_lit", 16'h0037, 1'b0, 1, "7", 0);
    b.data_in = 16'h0701;
    b.control_word_in = 1'b1;
    b.data_in_valid = 1'b1;
    @(negedge clock);
    b.data_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    vecs++;
    if ({o, o16} !== {10'h26f, 10'h26f}) begin
      fails++;
      $display("FAIL mid_third_byte: got %h/%h want 26f/26f", o, o16);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if ({o, o16} !== 20'h0) begin
      fails++;
      $display("FAIL mid_reset_async: got %h/%h want 000/000", o, o16);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vecs++;
      if ({o, o16} !== 20'h0) begin
        fails++;
        $display("FAIL mid_reset_hold %0d: got %h/%h want 000/000", i, o, o16);
      end
    end
    reset = 1'b1;
    idle_chk("mid_release_idle");
    item("post_reset_Z", 16'h005A, 1'b0, 1, "Z", 0);
    idle_chk("post_reset_idle");
  endtask
  initial begin
    vecs = 0;
    fails = 0;
    test_reset();
    test_literal();
    test_copy();
    test_overlap(0);
    test_ignore();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
